nf10_axis_rec_arbiter: RTL and testbench
========================================

# nf10_axis_rec_arbiter

Packet-granular round-robin arbiter sharing one AXI4-Stream simulation recorder (256-bit tdata, 32-bit tstrb, 128-bit tuser) among up to 8 upstream streams. It sits between several DUT output ports and a single `nf10_axis_sim_record` instance, so interleaved traffic is captured in one file without splitting packets. Grants are held from the first beat to `tlast`; a per-arbiter packet counter and source-port indication are exported for bench monitoring.

## Interface
- `C_AXIS_DATA_WIDTH`, 256, tdata width; tstrb width is `C_AXIS_DATA_WIDTH/8`
- `C_AXIS_TUSER_WIDTH`, 128, tuser width
- `C_NUM_PORTS`, 4, number of upstream streams, legal 2..8
- `aclk`  in  1  sole clock, all logic rising-edge
- `aresetn`  in  1  synchronous, active-low reset
- `s_axis_tdata`  in  N*256  port i occupies bits [i*256 +: 256]
- `s_axis_tstrb`  in  N*32  per-port byte strobes, same packing
- `s_axis_tuser`  in  N*128  per-port sideband, same packing
- `s_axis_tvalid`  in  N  per-port valid
- `s_axis_tready`  out  N  per-port ready
- `s_axis_tlast`  in  N  per-port end of packet
- `m_axis_tdata`  out  256, `m_axis_tstrb`  out  32, `m_axis_tuser`  out  128, `m_axis_tvalid`  out  1, `m_axis_tlast`  out  1  to the recorder
- `m_axis_tready`  in  1  from the recorder
- `grant_port`  out  3  index of the granted port; valid while `busy`=1
- `busy`  out  1  high in XFER
- `pkt_count`  out  8  packets forwarded, wraps 255 -> 0

## Operation
- States: IDLE, XFER.
- IDLE:
  - All `s_axis_tready`=0 and `m_axis_tvalid`=0.
  - If any `s_axis_tvalid` is set, pick the first valid port searching upward from `last_grant+1` modulo N.
  - Register the pick into `grant_port` and `last_grant`; next state is XFER.
- XFER:
  - `m_axis_tdata/tstrb/tuser/tlast/tvalid` are combinational selects of the granted port.
  - `s_axis_tready[grant]`=`m_axis_tready`; every other ready is 0.
  - A beat completes when `m_axis_tvalid & m_axis_tready`.
  - A beat with `tlast`=1 increments `pkt_count` and returns to IDLE.
- No switching mid-packet: if the granted port drops `tvalid` between beats, the grant holds indefinitely.
- Requests from other ports do not preempt the current grant.
- Arbitration looks only at `tvalid`; `tuser` content is never inspected.
- Upper slices for ports >= N are ignored.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `grant_port`=0, `pkt_count`=0.
  - `last_grant`=N-1, so port 0 wins first.
  - All readies 0, `m_axis_tvalid`=0.
- Arbitration latency is 1 cycle: `tvalid` seen in IDLE at cycle t gives XFER at t+1, with the first beat able to transfer at t+1.
- Single-beat packets (`tlast` on the first beat) return to IDLE at t+2, so the peak rate is 1 packet per 2 cycles.
- Multi-beat packets stream at 1 beat per cycle with no bubbles inside a packet.
- Inter-packet gap is 1 cycle.
- Simultaneous requests are served in round-robin order; a port that just finished has lowest priority next.
- Reset asserted mid-packet: the state returns to IDLE on that edge and the output drops `tvalid`. The truncated packet is not counted. Recovery is the bench's responsibility.
- `pkt_count` wraps 255 -> 0 with no saturation or flag.
- Back-pressure: `m_axis_tready`=0 stalls the granted port only. Data and `tvalid` on the master side stay stable, because they are pure selects of a stable slave.

## Structure
- Package `nf10_axis_rec_arb_pkg`:
  - state enum (IDLE, XFER)
  - localparams for default widths and `C_MAX_PORTS`=8
  - port-index width (3)
- Sub-module `nf10_rr_pick`: combinational round-robin priority picker. Inputs are a request vector and `last_grant`; outputs are `grant_idx` and `any_req`.
- The top level holds the FSM, grant/last_grant registers, datapath mux and counter.

## Test plan
- Reset then port 0 sends a 3-beat packet, `m_axis_tready`=1 -> `busy` rises next cycle, three beats out with `grant_port`=0, `pkt_count`=1, IDLE after `tlast`.
- All 4 ports hold 1-beat packets continuously -> grant order 0,1,2,3,0, with one output beat every 2 cycles.
- Port 1 mid-packet drops `tvalid` for 5 cycles while port 2 requests -> grant stays 1, and port 2 is served only after port 1's `tlast`.
- `m_axis_tready` toggled 1010 during a 4-beat packet -> no beat lost or duplicated, and master outputs stay stable while stalled.
- 256 single-beat packets -> `pkt_count` returns to 0.
- `aresetn` low during beat 2 of 4 -> next cycle `m_axis_tvalid`=0, `busy`=0, `pkt_count` unchanged at 0, and port 0 is granted first after release.

Source files
------------

// File: rtl/nf10_axis_rec_arb_pkg.sv
// rtl/nf10_axis_rec_arb_pkg.sv - shared types and constants for the recorder arbiter
package nf10_axis_rec_arb_pkg;

    localparam int C_DEF_DATA_WIDTH  = 256;
    localparam int C_DEF_TUSER_WIDTH = 128;
    localparam int C_DEF_NUM_PORTS   = 4;
    localparam int C_MAX_PORTS       = 8;
    localparam int C_PORT_IDX_W      = 3;

    typedef logic [C_PORT_IDX_W-1:0] port_idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    // Operands never exceed 2*n-2, so one conditional subtract replaces a modulo.
    function automatic int wrap_idx(input int sum, input int n);
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/nf10_rr_pick.sv
// rtl/nf10_rr_pick.sv - combinational round-robin picker, searches upward from last_grant+1
module nf10_rr_pick
    import nf10_axis_rec_arb_pkg::*;
#(
    parameter int C_NUM_PORTS = C_DEF_NUM_PORTS
) (
    input  logic [C_NUM_PORTS-1:0] i_req,
    input  port_idx_t              i_last_grant,
    output port_idx_t              o_grant_idx,
    output logic                   o_any_req
);

    int w_dist;
    int w_best;

    // Each port's priority is its distance from last_grant+1; the smallest requesting distance wins.
    always_comb begin
        o_grant_idx = '0;
        o_any_req   = 1'b0;
        w_dist      = 0;
        w_best      = C_NUM_PORTS;
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            w_dist = wrap_idx(i + C_NUM_PORTS - 1 - int'(i_last_grant), C_NUM_PORTS);
            if (i_req[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                o_grant_idx = port_idx_t'(i);
                o_any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf10_axis_rec_arbiter.sv
// rtl/nf10_axis_rec_arbiter.sv - packet-granular round-robin arbiter feeding one stream recorder
module nf10_axis_rec_arbiter
    import nf10_axis_rec_arb_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = C_DEF_DATA_WIDTH,
    parameter int C_AXIS_TUSER_WIDTH = C_DEF_TUSER_WIDTH,
    parameter int C_NUM_PORTS        = C_DEF_NUM_PORTS
) (
    input  logic                                        aclk,
    input  logic                                        aresetn,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                      s_axis_tvalid,
    output logic [C_NUM_PORTS-1:0]                      s_axis_tready,
    input  logic [C_NUM_PORTS-1:0]                      s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic                                        m_axis_tlast,
    output logic [C_PORT_IDX_W-1:0]                     grant_port,
    output logic                                        busy,
    output logic [7:0]                                  pkt_count
);

    localparam int C_STRB_W = C_AXIS_DATA_WIDTH / 8;

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    port_idx_t  r_grant;
    port_idx_t  r_last_grant;
    port_idx_t  w_pick;
    logic       w_any_req;
    logic       w_sel_valid;
    logic       w_sel_last;
    logic       w_pkt_done;
    logic [7:0] r_pkt_count;

    nf10_rr_pick #(
        .C_NUM_PORTS (C_NUM_PORTS)
    ) u_pick (
        .i_req        (s_axis_tvalid),
        .i_last_grant (r_last_grant),
        .o_grant_idx  (w_pick),
        .o_any_req    (w_any_req)
    );

    // Master side is a pure select of the granted slave, so a stalled beat stays stable.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        w_sel_valid   = 1'b0;
        w_sel_last    = 1'b0;
        s_axis_tready = '0;
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            if (r_grant == port_idx_t'(i)) begin
                m_axis_tdata = s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
                m_axis_tstrb = s_axis_tstrb[i*C_STRB_W +: C_STRB_W];
                m_axis_tuser = s_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
                w_sel_valid  = s_axis_tvalid[i];
                w_sel_last   = s_axis_tlast[i];
                s_axis_tready[i] = (r_state == ST_XFER) & m_axis_tready;
            end
        end
        m_axis_tvalid = (r_state == ST_XFER) & w_sel_valid;
        m_axis_tlast  = (r_state == ST_XFER) & w_sel_last;
    end

    assign w_pkt_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req)  w_state_nxt = ST_XFER;
            ST_XFER: if (w_pkt_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= port_idx_t'(C_NUM_PORTS - 1);
            r_pkt_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
            end
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + 8'd1;
            end
        end
    end

    assign grant_port = r_grant;
    assign busy       = (r_state == ST_XFER);
    assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_nf10_axis_rec_arbiter.sv
// tb/tb_nf10_axis_rec_arbiter.sv - self-checking bench for nf10_axis_rec_arbiter
module tb_nf10_axis_rec_arbiter;

    localparam int NP = 4;
    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
        logic          first;
        int            gap;
    } beat_t;

    typedef struct {
        int    port;
        beat_t b;
        int    cyc;
    } rec_t;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [NP*DW-1:0] s_tdata = '0;
    logic [NP*SW-1:0] s_tstrb = '0;
    logic [NP*UW-1:0] s_tuser = '0;
    logic [NP-1:0]    s_tvalid = '0;
    logic [NP-1:0]    s_tready;
    logic [NP-1:0]    s_tlast = '0;
    logic [DW-1:0]    m_tdata;
    logic [SW-1:0]    m_tstrb;
    logic [UW-1:0]    m_tuser;
    logic             m_tvalid;
    logic             m_tready = 1'b0;
    logic             m_tlast;
    logic [2:0]       grant_port;
    logic             busy;
    logic [7:0]       pkt_count;

    always #5 aclk = ~aclk;

    nf10_axis_rec_arbiter #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .C_NUM_PORTS        (NP)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .grant_port    (grant_port),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    tready_mode = 0;
    int    m_last = NP - 1;
    int    exp_pkts = 0;
    beat_t pq[NP][$];
    rec_t  outq[$];
    rec_t  expq[$];

    function automatic beat_t rand_beat(input bit first, input bit last, input int gap);
        beat_t b;
        for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
        b.strb = $urandom();
        for (int w = 0; w < UW / 32; w++) b.user[w*32 +: 32] = $urandom();
        b.last  = last;
        b.first = first;
        b.gap   = gap;
        return b;
    endfunction

    function automatic rec_t mk_rec(input int port, input beat_t b, input int c);
        rec_t r;
        r.port = port;
        r.b    = b;
        r.cyc  = c;
        return r;
    endfunction

    task automatic add_pkt(input int p, input int len, input int gmax);
        for (int j = 0; j < len; j++)
            pq[p].push_back(rand_beat(j == 0, j == len - 1, (j == 0) ? 0 : $urandom_range(0, gmax)));
    endtask

    function automatic bit pending();
        for (int i = 0; i < NP; i++) if (pq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: sources present queue fronts after the edge, everything is sampled mid-cycle.
    task automatic step();
        beat_t b;
        @(posedge aclk);
        #1;
        cyc++;
        for (int i = 0; i < NP; i++) begin
            if (pq[i].size() > 0) begin
                if (pq[i][0].gap > 0) begin
                    s_tvalid[i] = 1'b0;
                    pq[i][0].gap = pq[i][0].gap - 1;
                end else begin
                    s_tvalid[i] = 1'b1;
                end
                s_tdata[i*DW +: DW] = pq[i][0].data;
                s_tstrb[i*SW +: SW] = pq[i][0].strb;
                s_tuser[i*UW +: UW] = pq[i][0].user;
                s_tlast[i]          = pq[i][0].last;
            end else begin
                s_tvalid[i]         = 1'b0;
                s_tdata[i*DW +: DW] = '0;
                s_tstrb[i*SW +: SW] = '0;
                s_tuser[i*UW +: UW] = '0;
                s_tlast[i]          = 1'($urandom_range(0, 1));
            end
        end
        case (tready_mode)
            1:       m_tready = (cyc % 2 == 0);
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b1;
        endcase
        @(negedge aclk);
        for (int i = 0; i < NP; i++)
            if (s_tvalid[i] && s_tready[i]) void'(pq[i].pop_front());
        if (m_tvalid && m_tready) begin
            b.data = m_tdata; b.strb = m_tstrb; b.user = m_tuser;
            b.last = m_tlast; b.first = 1'b0; b.gap = 0;
            outq.push_back(mk_rec(int'(grant_port), b, cyc));
        end
    endtask

    // Reference: packets leave in round-robin order over non-empty port queues, whole packets at a time.
    task automatic model_build();
        beat_t cq[NP][$];
        beat_t b;
        int    p;
        bit    more;
        for (int i = 0; i < NP; i++) cq[i] = pq[i];
        more = 1'b1;
        while (more) begin
            p = -1;
            for (int k = 1; k <= NP; k++)
                if (p < 0 && cq[(m_last + k) % NP].size() > 0) p = (m_last + k) % NP;
            if (p < 0) begin
                more = 1'b0;
            end else begin
                do begin
                    b = cq[p].pop_front();
                    expq.push_back(mk_rec(p, b, 0));
                end while (!b.last);
                m_last = p;
                exp_pkts++;
            end
        end
    endtask

    function automatic int first_bad();
        int n;
        n = (outq.size() < expq.size()) ? outq.size() : expq.size();
        for (int i = 0; i < n; i++)
            if (outq[i].port != expq[i].port || outq[i].b.data !== expq[i].b.data ||
                outq[i].b.strb !== expq[i].b.strb || outq[i].b.user !== expq[i].b.user ||
                outq[i].b.last !== expq[i].b.last)
                return i;
        return -1;
    endfunction

    task automatic run_drain(input int max_cyc, output bit timed_out);
        int n;
        n = 0;
        while ((pending() || outq.size() < expq.size()) && n < max_cyc) begin
            step();
            n++;
        end
        timed_out = (n >= max_cyc);
        step();
        step();
    endtask

    task automatic flush();
        for (int i = 0; i < NP; i++) pq[i].delete();
        outq.delete();
        expq.delete();
    endtask

    task automatic reset_dut();
        aresetn = 1'b0;
        tready_mode = 0;
        flush();
        step();
        step();
        aresetn = 1'b1;
        m_last = NP - 1;
        exp_pkts = 0;
    endtask

    task automatic test_reset();
        bit to;
        int fb;
        flush();
        add_pkt(0, 1, 0);
        add_pkt(1, 1, 0);
        step();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_tests++; if (grant_port !== 3'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant_port); end
        n_tests++; if (pkt_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", pkt_count); end
        n_tests++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid: got %0b expected 0", m_tvalid); end
        n_tests++; if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL reset_sready: got %b expected 0000", s_tready); end
        aresetn = 1'b1;
        m_last = NP - 1;
        exp_pkts = 0;
        model_build();
        step();
        n_tests++; if (busy !== 1'b1 || grant_port !== 3'd0) begin n_fail++; $display("FAIL reset_first_grant: got busy=%0b port=%0d expected busy=1 port=0", busy, grant_port); end
        run_drain(100, to);
        fb = first_bad();
        n_tests++; if (to || outq.size() != expq.size() || fb != -1) begin n_fail++; $display("FAIL reset_stream: got %0d beats (bad idx %0d) expected %0d", outq.size(), fb, expq.size()); end
        n_tests++; if (pkt_count !== 8'd2) begin n_fail++; $display("FAIL reset_pktcount: got %0d expected 2", pkt_count); end
    endtask

    task automatic test_single_3beat();
        bit to;
        int c0;
        int bad_cyc;
        reset_dut();
        add_pkt(0, 3, 0);
        model_build();
        step();
        c0 = cyc;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL s3_idle_first: got busy=%0b expected 0", busy); end
        step();
        n_tests++; if (busy !== 1'b1 || grant_port !== 3'd0) begin n_fail++; $display("FAIL s3_grant: got busy=%0b port=%0d expected busy=1 port=0", busy, grant_port); end
        run_drain(50, to);
        n_tests++; if (to || outq.size() != 3 || first_bad() != -1) begin n_fail++; $display("FAIL s3_stream: got %0d beats expected 3", outq.size()); end
        bad_cyc = 0;
        foreach (outq[j]) if (outq[j].cyc != c0 + 1 + j) bad_cyc++;
        n_tests++; if (bad_cyc != 0) begin n_fail++; $display("FAIL s3_timing: got %0d beats off-cycle expected 0", bad_cyc); end
        n_tests++; if (pkt_count !== 8'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL s3_done: got count=%0d busy=%0b expected count=1 busy=0", pkt_count, busy); end
    endtask

    task automatic test_round_robin();
        bit to;
        int order_bad;
        int space_bad;
        reset_dut();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) add_pkt(p, 1, 0);
        model_build();
        run_drain(100, to);
        n_tests++; if (to || outq.size() != 8 || first_bad() != -1) begin n_fail++; $display("FAIL rr_stream: got %0d beats (bad idx %0d) expected 8", outq.size(), first_bad()); end
        order_bad = 0;
        space_bad = 0;
        foreach (outq[j]) begin
            if (outq[j].port != j % NP) order_bad++;
            if (j > 0 && outq[j].cyc - outq[j-1].cyc != 2) space_bad++;
        end
        n_tests++; if (order_bad != 0) begin n_fail++; $display("FAIL rr_order: got %0d out-of-order grants expected 0", order_bad); end
        n_tests++; if (space_bad != 0) begin n_fail++; $display("FAIL rr_rate: got %0d gaps not equal to 2 cycles expected 0", space_bad); end
        n_tests++; if (pkt_count !== 8'd8) begin n_fail++; $display("FAIL rr_count: got %0d expected 8", pkt_count); end
    endtask

    task automatic test_hold();
        int n;
        int gap_seen;
        int hold_bad;
        outq.delete();
        expq.delete();
        add_pkt(1, 4, 0);
        pq[1][1].gap = 5;
        add_pkt(2, 2, 0);
        model_build();
        n = 0;
        gap_seen = 0;
        hold_bad = 0;
        while ((pending() || outq.size() < expq.size()) && n < 100) begin
            step();
            n++;
            if (busy && !m_tvalid) begin
                gap_seen++;
                if (grant_port !== 3'd1 || s_tready[2] !== 1'b0) hold_bad++;
            end
        end
        step();
        step();
        n_tests++; if (n >= 100 || outq.size() != 6 || first_bad() != -1) begin n_fail++; $display("FAIL hold_stream: got %0d beats (bad idx %0d) expected 6", outq.size(), first_bad()); end
        n_tests++; if (gap_seen != 5 || hold_bad != 0) begin n_fail++; $display("FAIL hold_grant: got gap=%0d bad=%0d expected gap=5 bad=0", gap_seen, hold_bad); end
        if (outq.size() == 6) begin
            n_tests++; if (outq[3].cyc - outq[0].cyc != 8 || outq[4].cyc - outq[3].cyc != 2) begin
                n_fail++; $display("FAIL hold_timing: got span=%0d handover=%0d expected 8 and 2", outq[3].cyc - outq[0].cyc, outq[4].cyc - outq[3].cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        bit prev_stall;
        int stalls;
        int stable_bad;
        logic [DW-1:0] pd;
        logic [SW-1:0] ps;
        logic [UW-1:0] pu;
        logic pl;
        outq.delete();
        expq.delete();
        tready_mode = 1;
        add_pkt(3, 4, 0);
        model_build();
        n = 0; prev_stall = 1'b0; stalls = 0; stable_bad = 0;
        pd = '0; ps = '0; pu = '0; pl = 1'b0;
        while ((pending() || outq.size() < expq.size()) && n < 100) begin
            step();
            n++;
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== pd || m_tstrb !== ps ||
                               m_tuser !== pu || m_tlast !== pl)) stable_bad++;
            prev_stall = m_tvalid && !m_tready;
            if (prev_stall) stalls++;
            pd = m_tdata; ps = m_tstrb; pu = m_tuser; pl = m_tlast;
        end
        tready_mode = 0;
        step();
        step();
        n_tests++; if (n >= 100 || outq.size() != 4 || first_bad() != -1) begin n_fail++; $display("FAIL bp_stream: got %0d beats (bad idx %0d) expected 4", outq.size(), first_bad()); end
        n_tests++; if (stalls < 3 || stable_bad != 0) begin n_fail++; $display("FAIL bp_stable: got stalls=%0d unstable=%0d expected stalls>=3 unstable=0", stalls, stable_bad); end
        n_tests++; if (pkt_count !== 8'(exp_pkts)) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", pkt_count, 8'(exp_pkts)); end
    endtask

    task automatic test_random();
        bit to;
        outq.delete();
        expq.delete();
        tready_mode = 2;
        for (int p = 0; p < NP; p++)
            for (int k = $urandom_range(1, 4); k > 0; k--) add_pkt(p, $urandom_range(1, 6), 3);
        model_build();
        run_drain(4000, to);
        tready_mode = 0;
        n_tests++; if (to) begin n_fail++; $display("FAIL rand_timeout: got timeout expected drained"); end
        n_tests++; if (outq.size() != expq.size() || first_bad() != -1) begin n_fail++; $display("FAIL rand_stream: got %0d beats (bad idx %0d) expected %0d", outq.size(), first_bad(), expq.size()); end
        n_tests++; if (pkt_count !== 8'(exp_pkts)) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", pkt_count, 8'(exp_pkts)); end
    endtask

    task automatic test_wrap();
        bit to;
        reset_dut();
        tready_mode = 2;
        for (int k = 0; k < 256; k++) add_pkt($urandom_range(0, NP - 1), 1, 0);
        model_build();
        run_drain(4000, to);
        tready_mode = 0;
        n_tests++; if (to || outq.size() != 256 || first_bad() != -1) begin n_fail++; $display("FAIL wrap_stream: got %0d beats (bad idx %0d) expected 256", outq.size(), first_bad()); end
        n_tests++; if (pkt_count !== 8'h00) begin n_fail++; $display("FAIL wrap_count: got %0d expected 0", pkt_count); end
    endtask

    task automatic test_reset_midpkt();
        bit to;
        reset_dut();
        add_pkt(0, 4, 0);
        step();
        step();
        step();
        n_tests++; if (m_tvalid !== 1'b1 || outq.size() != 2) begin n_fail++; $display("FAIL rst_mid_pre: got valid=%0b beats=%0d expected valid=1 beats=2", m_tvalid, outq.size()); end
        aresetn = 1'b0;
        step();
        n_tests++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drop: got valid=%0b busy=%0b expected 0 0", m_tvalid, busy); end
        n_tests++; if (pkt_count !== 8'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", pkt_count); end
        flush();
        aresetn = 1'b1;
        m_last = NP - 1;
        exp_pkts = 0;
        add_pkt(2, 1, 0);
        add_pkt(0, 1, 0);
        model_build();
        run_drain(100, to);
        n_tests++; if (to || outq.size() != 2 || first_bad() != -1) begin n_fail++; $display("FAIL rst_mid_stream: got %0d beats expected 2", outq.size()); end
        if (outq.size() > 0) begin
            n_tests++; if (outq[0].port != 0) begin n_fail++; $display("FAIL rst_mid_first: got port %0d expected 0", outq[0].port); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_3beat();
        test_round_robin();
        test_hold();
        test_backpressure();
        test_random();
        test_wrap();
        test_reset_midpkt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
